// File: rtl/kyber_hpm_pkg.sv
`default_nettype none
// ============================================================================
// Module : kyber_hpm_pkg
// Brief  : Shared opcodes, FSM encoding and defaults for the Kyber HPM
//          command front-end.
// Rev    : 1.0 - initial release
// ============================================================================
package kyber_hpm_pkg;

  localparam int DEFAULT_DW = 12;
  localparam int NUM_OPS    = 11;

  localparam logic [3:0] OP_LOAD_A_F    = 4'd0;
  localparam logic [3:0] OP_LOAD_A_I    = 4'd1;
  localparam logic [3:0] OP_LOAD_B_F    = 4'd2;
  localparam logic [3:0] OP_LOAD_B_I    = 4'd3;
  localparam logic [3:0] OP_READ_A      = 4'd4;
  localparam logic [3:0] OP_READ_B      = 4'd5;
  localparam logic [3:0] OP_START_AB    = 4'd6;
  localparam logic [3:0] OP_START_POS   = 4'd7;
  localparam logic [3:0] OP_START_FNTT  = 4'd8;
  localparam logic [3:0] OP_START_PWM2  = 4'd9;
  localparam logic [3:0] OP_START_INTT  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } hpm_state_e;

  // Opcodes 11..15 have no core strobe behind them.
  function automatic logic op_is_legal(input logic [3:0] op);
    return op < 4'(NUM_OPS);
  endfunction

  // One-hot core strobe whose bit index equals the opcode.
  function automatic logic [NUM_OPS-1:0] op_onehot(input logic [3:0] op);
    logic [NUM_OPS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      oh[i] = (op == 4'(i));
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpm_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module : hpm_pipe_reg
// Brief  : WIDTH-bit, DEPTH-stage free-running delay line with synchronous
//          active-high reset clearing every stage. DEPTH must be >= 1.
// Rev    : 1.0 - initial release
// ============================================================================
module hpm_pipe_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift data one stage per clock; reset flushes anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/kyber_hpm_cmd_top.sv
`default_nettype none
// ============================================================================
// Module : kyber_hpm_cmd_top
// Brief  : Opcode + valid/ready command front-end for the Kyber HPM core.
//          IDLE/ISSUE/WAIT sequencer with done tracking and timeout, plus
//          configurable register pipelines on the data/strobe/done paths.
// Option : define HPM_CMD_FIFO_EN for a 4-entry command FIFO in front of
//          the sequencer (cmd_ready then means "FIFO not full").
// Rev    : 1.0 - initial release
// ============================================================================
module kyber_hpm_cmd_top
  import kyber_hpm_pkg::*;
#(
  parameter int PE_NUMBER  = 1,
  parameter int DW         = DEFAULT_DW,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_op,
  input  logic [DW*PE_NUMBER-1:0]   din,
  output logic [DW*PE_NUMBER-1:0]   dout,
  output logic                      done,
  output logic                      busy,
  output logic                      err,
  output logic [NUM_OPS-1:0]        core_strobe,
  output logic [DW*PE_NUMBER-1:0]   core_din,
  input  logic [DW*PE_NUMBER-1:0]   core_dout,
  input  logic                      core_done
);

  localparam int BW = DW * PE_NUMBER;

  hpm_state_e           state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [NUM_OPS-1:0]   strobe_d;
  logic                 done_evt_d;

  logic                 src_valid;
  logic [3:0]           src_op;
  logic                 illegal_cmd;

`ifdef HPM_CMD_FIFO_EN
  logic [3:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       fifo_full, fifo_empty, push, pop, accept;

  assign fifo_full   = (count_q == 3'd4);
  assign fifo_empty  = (count_q == 3'd0);
  assign cmd_ready   = !fifo_full;
  assign accept      = cmd_valid && cmd_ready;
  // Illegal opcodes are answered with err at the door and never queued.
  assign push        = accept && op_is_legal(cmd_op);
  assign illegal_cmd = accept && !op_is_legal(cmd_op);
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;
  assign src_valid   = !fifo_empty;
  assign src_op      = fifo_q[rd_ptr_q];

  // Command FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= cmd_op;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic accept;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign illegal_cmd = accept && !op_is_legal(cmd_op);
  assign src_valid   = accept && op_is_legal(cmd_op);
  assign src_op      = cmd_op;
`endif

  // Sequencer next state: launch one strobe, then wait for done or timeout.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    err_d      = illegal_cmd;
    strobe_d   = '0;
    done_evt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (src_valid) begin
          op_d    = src_op;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        strobe_d = op_onehot(op_q);
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // core_done wins over a simultaneous timeout.
        if (core_done) begin
          done_evt_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (&cnt_q) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, latched opcode, timeout counter and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

  // Host data and strobe share the same delay so they stay aligned at the core.
  hpm_pipe_reg #(.WIDTH(BW), .DEPTH(IN_STAGES)) u_din_pipe (
    .clk(clk), .reset(reset), .d_i(din), .q_o(core_din)
  );

  hpm_pipe_reg #(.WIDTH(NUM_OPS), .DEPTH(IN_STAGES)) u_strobe_pipe (
    .clk(clk), .reset(reset), .d_i(strobe_d), .q_o(core_strobe)
  );

  // Result data and completion pulse share the return delay.
  hpm_pipe_reg #(.WIDTH(BW), .DEPTH(OUT_STAGES)) u_dout_pipe (
    .clk(clk), .reset(reset), .d_i(core_dout), .q_o(dout)
  );

  hpm_pipe_reg #(.WIDTH(1), .DEPTH(OUT_STAGES)) u_done_pipe (
    .clk(clk), .reset(reset), .d_i(done_evt_d), .q_o(done)
  );

endmodule
`default_nettype wire

// File: tb/tb_kyber_hpm_cmd_top.sv
`default_nettype none
// ============================================================================
// Module : tb_kyber_hpm_cmd_top
// Brief  : Directed self-checking bench for kyber_hpm_cmd_top
//          (PE_NUMBER=4, DW=12, IN_STAGES=3, OUT_STAGES=2, TIMEOUT_W=4).
//          Inputs change 1 time unit after the rising edge; outputs are
//          sampled at that same point, i.e. away from the active edge.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_kyber_hpm_cmd_top;

  localparam int PE   = 4;
  localparam int DW   = 12;
  localparam int INS  = 3;
  localparam int OUTS = 2;
  localparam int TW   = 4;
  localparam int BW   = PE * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [BW-1:0] din;
  logic [BW-1:0] dout;
  logic          done;
  logic          busy;
  logic          err;
  logic [10:0]   core_strobe;
  logic [BW-1:0] core_din;
  logic [BW-1:0] core_dout;
  logic          core_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kyber_hpm_cmd_top #(
    .PE_NUMBER(PE), .DW(DW), .IN_STAGES(INS), .OUT_STAGES(OUTS), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .din(din), .dout(dout), .done(done), .busy(busy),
    .err(err), .core_strobe(core_strobe), .core_din(core_din),
    .core_dout(core_dout), .core_done(core_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one accepted edge; returns in the ISSUE cycle.
  task automatic issue(input logic [3:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
`ifdef HPM_CMD_FIFO_EN
    tick();
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; din = '0;
    core_dout = '0; core_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL reset_done_err: got %0b/%0b want 0/0", done, err); end
    n_checks++; if (core_strobe !== 11'h000) begin n_errors++; $display("FAIL reset_strobe: got %h want 000", core_strobe); end
    n_checks++; if (dout !== '0 || core_din !== '0) begin n_errors++; $display("FAIL reset_data: got %h/%h want 0/0", dout, core_din); end
  endtask

  task automatic test_start_fntt();
    logic [10:0] exp;
    issue(4'd8);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL fntt_busy_issue: got %0b want 1", busy); end
`ifndef HPM_CMD_FIFO_EN
    n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL fntt_ready_issue: got %0b want 0", cmd_ready); end
`endif
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == INS) ? 11'h100 : 11'h000;
      n_checks++; if (core_strobe !== exp) begin n_errors++; $display("FAIL fntt_strobe_k%0d: got %h want %h", k, core_strobe, exp); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL fntt_busy_k%0d: got %0b want 1", k, busy); end
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL fntt_after_core_done: busy/done got %0b/%0b want 0/0", busy, done); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL fntt_done_pulse: got %0b want 1", done); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL fntt_done_width: got %0b want 0", done); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [2];
    ops[0] = 4'd13;
    ops[1] = 4'd11;
    for (int j = 0; j < 2; j++) begin
      cmd_valid = 1'b1; cmd_op = ops[j];
      tick();
      cmd_valid = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL illegal_err_op%0d: got %0b want 1", ops[j], err); end
      n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL illegal_state_op%0d: busy/ready got %0b/%0b want 0/1", ops[j], busy, cmd_ready); end
      tick();
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL illegal_err_width_op%0d: got %0b want 0", ops[j], err); end
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (core_strobe !== 11'h000 || busy !== 1'b0) begin n_errors++; $display("FAIL illegal_quiet_op%0d_k%0d: strobe/busy got %h/%0b want 000/0", ops[j], k, core_strobe, busy); end
        tick();
      end
    end
    // A stray core_done while idle must not produce a done pulse.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL idle_core_done_k%0d: got %0b want 0", k, done); end
      tick();
    end
  endtask

  task automatic test_timeout();
    // No core_done: err appears when the 4-bit counter has sat at 15.
    issue(4'd6);
    tick();
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL timeout_wait_k%0d: err/busy got %0b/%0b want 0/1", k, err, busy); end
      tick();
    end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL timeout_err: got %0b want 1", err); end
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL timeout_idle: busy/ready got %0b/%0b want 0/1", busy, cmd_ready); end
    tick();
    n_checks++; if (err !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL timeout_after: err/done got %0b/%0b want 0/0", err, done); end
    // core_done on the saturating cycle counts as completion.
    issue(4'd6);
    tick();
    for (int k = 0; k < 15; k++) tick();
    core_done = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL edge_busy: got %0b want 1", busy); end
    tick();
    core_done = 1'b0;
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL edge_no_err: err/busy got %0b/%0b want 0/0", err, busy); end
    tick();
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL edge_done: done/err got %0b/%0b want 1/0", done, err); end
    tick();
  endtask

  task automatic test_datapath();
    logic [BW-1:0] a, b, ea, eb;
    a = 48'h123456789ABC;
    b = 48'hFFF000FFF000;
    din = a; core_dout = b;
    tick();
    din = '0; core_dout = '0;
    for (int k = 1; k <= 4; k++) begin
      ea = (k == INS)  ? a : '0;
      eb = (k == OUTS) ? b : '0;
      n_checks++; if (core_din !== ea) begin n_errors++; $display("FAIL din_pipe_k%0d: got %h want %h", k, core_din, ea); end
      n_checks++; if (dout !== eb) begin n_errors++; $display("FAIL dout_pipe_k%0d: got %h want %h", k, dout, eb); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    issue(4'd10);
    tick(); tick();
    din = 48'hAAAAAAAAAAAA;
    reset = 1'b1; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_flags: done/err/busy got %0b/%0b/%0b want 0/0/0", done, err, busy); end
    n_checks++; if (core_strobe !== 11'h000 || core_din !== '0 || dout !== '0) begin n_errors++; $display("FAIL rst_mid_data: strobe/core_din/dout got %h/%h/%h want 0", core_strobe, core_din, dout); end
    reset = 1'b0; din = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (done !== 1'b0 || err !== 1'b0 || core_strobe !== 11'h000) begin n_errors++; $display("FAIL rst_mid_quiet_k%0d: done/err/strobe got %0b/%0b/%h want 0/0/000", k, done, err, core_strobe); end
    end
    issue(4'd0);
    tick(); tick(); tick();
    n_checks++; if (core_strobe !== 11'h001) begin n_errors++; $display("FAIL rst_after_strobe: got %h want 001", core_strobe); end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_after_busy: got %0b want 0", busy); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rst_after_done: got %0b want 1", done); end
    tick();
  endtask

`ifdef HPM_CMD_FIFO_EN
  task automatic test_back_to_back();
    int pushed, strobes, dones, resp, saw_full;
    pushed = 0; strobes = 0; dones = 0; resp = -1; saw_full = 0;
    for (int c = 0; c < 200; c++) begin
      if (core_strobe !== 11'h000) begin
        n_checks++; if (core_strobe !== (11'h001 << strobes)) begin n_errors++; $display("FAIL fifo_order_%0d: got %h want %h", strobes, core_strobe, 11'h001 << strobes); end
        strobes++;
        resp = 2;
      end
      core_done = (resp == 0);
      if (resp >= 0) resp--;
      if (done === 1'b1) dones++;
      if (cmd_ready === 1'b0) saw_full = 1;
      cmd_valid = (pushed < 5);
      cmd_op    = 4'(pushed);
      if (cmd_valid && cmd_ready) pushed++;
      tick();
    end
    cmd_valid = 1'b0; core_done = 1'b0;
    n_checks++; if (dones != 5 || strobes != 5) begin n_errors++; $display("FAIL fifo_counts: dones/strobes got %0d/%0d want 5/5", dones, strobes); end
    n_checks++; if (saw_full != 1) begin n_errors++; $display("FAIL fifo_full_seen: got %0d want 1", saw_full); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_fntt();
    test_illegal();
    test_timeout();
    test_datapath();
    test_reset_mid();
`ifdef HPM_CMD_FIFO_EN
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
